// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer for the Tomasulo core and the
// sole writer of the architectural register file. Dispatch allocates entries
// at the tail, CDB broadcasts fill them by tag, and completed entries retire
// from the head at most one per cycle through the register-file write port.
// Optional feature macro: ROB_CDB_BYPASS_EN lets a not-yet-done head entry
// retire in the same cycle its CDB result arrives.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [4:0]       alloc_rd,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             flush,
  output logic             reg_write,
  output logic [4:0]       write_addr,
  output logic [31:0]      write_data,
  output logic             commit_valid,
  output logic [TAG_W:0]   count,
  output logic             empty
);

  localparam logic [TAG_W:0] FULL_CNT = DEPTH[TAG_W:0];

  // Control state (reset) and per-entry payload (not reset)
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [4:0]       rd_q    [DEPTH];
  logic [4:0]       rd_d    [DEPTH];
  logic [31:0]      value_q [DEPTH];
  logic [31:0]      value_d [DEPTH];

  logic        alloc_fire;
  logic        cdb_hit;
  logic        commit;
  logic [31:0] commit_value;
  logic [4:0]  head_rd;

  // Retirement decision and the value presented to the register file
  always_comb begin
    head_rd      = rd_q[head_q];
    alloc_fire   = alloc_valid && (count_q < FULL_CNT) && !flush;
    cdb_hit      = cdb_valid && valid_q[cdb_tag];
`ifdef ROB_CDB_BYPASS_EN
    // A head entry still waiting on its result can retire straight off the CDB.
    commit       = valid_q[head_q] && !flush &&
                   (done_q[head_q] || (cdb_valid && (cdb_tag == head_q)));
    commit_value = done_q[head_q] ? value_q[head_q] : cdb_data;
`else
    commit       = valid_q[head_q] && done_q[head_q] && !flush;
    commit_value = value_q[head_q];
`endif
  end

  // Register-file port and status outputs; address/data are zero unless writing
  always_comb begin
    commit_valid = commit;
    reg_write    = commit && (head_rd != 5'd0);
    write_addr   = reg_write ? head_rd : 5'd0;
    write_data   = reg_write ? commit_value : 32'd0;
    alloc_ready  = (count_q < FULL_CNT);
    alloc_tag    = tail_q;
    count        = count_q;
    empty        = (count_q == '0);
  end

  // Next-state: flush wins; otherwise CDB fill, head retire and tail allocate
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rd_d    = rd_q;
    value_d = value_q;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // CDB on an invalid entry is dropped; on a done entry it overwrites.
      if (cdb_hit) begin
        done_d[cdb_tag]  = 1'b1;
        value_d[cdb_tag] = cdb_data;
      end
      // Retire after the fill so a same-edge CDB on the head cannot revive it.
      if (commit) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + 1'b1;
      end
      // alloc_fire needs count < DEPTH, so the tail never lands on a live
      // entry, including the head being retired this same edge.
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        rd_d[tail_q]    = alloc_rd;
        tail_d          = tail_q + 1'b1;
      end
      case ({alloc_fire, commit})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    rd_q    <= rd_d;
    value_q <= value_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer (default build, no CDB bypass).
// Stimulus pushes expected retirements; a negedge monitor pops and compares
// them and also checks status snapshots requested by the stimulus.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [4:0]  alloc_rd = 5'd0;
  logic [2:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = 3'd0;
  logic [31:0] cdb_data = 32'd0;
  logic        flush = 1'b0;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        commit_valid;
  logic [3:0]  count;
  logic        empty;

  reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
    .commit_valid(commit_valid), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Scoreboard: {reg_write, write_addr, write_data} per expected retirement
  logic [37:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Status snapshot requested by stimulus
  logic        st_chk = 1'b0;
  string       st_name = "";
  logic [3:0]  exp_cnt = 4'd0;
  logic        exp_rdy = 1'b1;
  logic [2:0]  exp_tag = 3'd0;
  logic        end_chk = 1'b0;

  // Monitor
  always @(negedge clk) begin
    logic [37:0] e;
    if (commit_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_commit: got rw=%0d addr=%0d data=%h, required no commit",
                 reg_write, write_addr, write_data);
      end else begin
        e = exp_q.pop_front();
        if ({reg_write, write_addr, write_data} !== e) begin
          n_fail++;
          $display("FAIL retire: got rw=%0d addr=%0d data=%h, required rw=%0d addr=%0d data=%h",
                   reg_write, write_addr, write_data, e[37], e[36:32], e[31:0]);
        end
      end
    end else begin
      n_tests++;
      if (reg_write !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) begin
        n_fail++;
        $display("FAIL idle_port: got rw=%0d addr=%0d data=%h, required all zero",
                 reg_write, write_addr, write_data);
      end
    end
    if (st_chk) begin
      n_tests++;
      if (count !== exp_cnt || alloc_ready !== exp_rdy ||
          empty !== (exp_cnt == 4'd0) || alloc_tag !== exp_tag) begin
        n_fail++;
        $display("FAIL %s: got count=%0d ready=%0d empty=%0d tag=%0d, required count=%0d ready=%0d empty=%0d tag=%0d",
                 st_name, count, alloc_ready, empty, alloc_tag,
                 exp_cnt, exp_rdy, (exp_cnt == 4'd0), exp_tag);
      end
    end
    if (end_chk) begin
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_retire: got %0d retirements outstanding, required 0", exp_q.size());
      end
    end
  end

  task automatic step(input logic av, input logic [4:0] rd, input logic cv,
                      input logic [2:0] tg, input logic [31:0] d, input logic fl);
    alloc_valid = av; alloc_rd = rd;
    cdb_valid = cv; cdb_tag = tg; cdb_data = d;
    flush = fl;
    @(posedge clk); #1;
    alloc_valid = 1'b0; alloc_rd = 5'd0;
    cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 32'd0;
    flush = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    step(1'b1, rd, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic cdb(input logic [2:0] tg, input logic [31:0] d);
    step(1'b0, 5'd0, 1'b1, tg, d, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic push(input logic rw, input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({rw, a, d});
  endtask

  task automatic expect_st(input string name, input logic [3:0] cnt,
                           input logic rdy, input logic [2:0] tg);
    st_name = name; exp_cnt = cnt; exp_rdy = rdy; exp_tag = tg;
    st_chk = 1'b1;
    @(negedge clk); #1;
    st_chk = 1'b0;
  endtask

  // Reset asserted mid-cycle, checked before any clock edge, then released
  task automatic do_reset(input string name);
    #2;
    rst_n = 1'b0;
    expect_st(name, 4'd0, 1'b1, 3'd0);
    rst_n = 1'b1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset_init", 4'd0, 1'b1, 3'd0);
    rst_n = 1'b1;

    // Single instruction: rd=5, tag 0
    expect_st("pre_alloc", 4'd0, 1'b1, 3'd0);
    alloc(5'd5);
    expect_st("one_alloc", 4'd1, 1'b1, 3'd1);
    push(1'b1, 5'd5, 32'hDEADBEEF);
    cdb(3'd0, 32'hDEADBEEF);
    expect_st("single_done", 4'd1, 1'b1, 3'd1);
    idle();
    expect_st("single_retired", 4'd0, 1'b1, 3'd1);

    // Out-of-order completion, in-order retirement
    do_reset("reset_before_ooo");
    alloc(5'd1); alloc(5'd2); alloc(5'd3);
    push(1'b1, 5'd1, 32'h11);
    push(1'b1, 5'd2, 32'h22);
    push(1'b1, 5'd3, 32'h33);
    cdb(3'd2, 32'h33);
    cdb(3'd1, 32'h22);
    cdb(3'd0, 32'h11);
    expect_st("ooo_all_done", 4'd3, 1'b1, 3'd3);
    idle();
    expect_st("ooo_retire1", 4'd2, 1'b1, 3'd3);
    idle();
    expect_st("ooo_retire2", 4'd1, 1'b1, 3'd3);
    idle();
    expect_st("ooo_retire3", 4'd0, 1'b1, 3'd3);

    // Full and wrap-around
    do_reset("reset_before_full");
    for (int i = 0; i < 8; i++) alloc(5'(8 + i));
    expect_st("full", 4'd8, 1'b0, 3'd0);
    alloc(5'd20);
    expect_st("alloc_ignored_full", 4'd8, 1'b0, 3'd0);
    push(1'b1, 5'd8, 32'hA0);
    cdb(3'd0, 32'hA0);
    expect_st("full_head_done", 4'd8, 1'b0, 3'd0);
    alloc(5'd22);
    expect_st("slot_freed", 4'd7, 1'b1, 3'd0);
    alloc(5'd21);
    expect_st("wrap_alloc", 4'd8, 1'b0, 3'd1);
    for (int t = 1; t < 8; t++) begin
      push(1'b1, 5'(8 + t), 32'hB0 + 32'(t));
      cdb(3'(t), 32'hB0 + 32'(t));
    end
    push(1'b1, 5'd21, 32'hC0);
    cdb(3'd0, 32'hC0);
    idle(); idle(); idle();
    expect_st("wrap_drained", 4'd0, 1'b1, 3'd1);

    // x0 destination: commit without register write
    do_reset("reset_before_x0");
    push(1'b0, 5'd0, 32'd0);
    alloc(5'd0);
    cdb(3'd0, 32'h1234);
    idle();
    expect_st("x0_retired", 4'd0, 1'b1, 3'd1);

    // CDB on the same edge as the allocation of its tag is ignored
    do_reset("reset_before_same_edge");
    step(1'b1, 5'd9, 1'b1, 3'd0, 32'h99, 1'b0);
    idle();
    expect_st("cdb_same_edge_ignored", 4'd1, 1'b1, 3'd1);
    push(1'b1, 5'd9, 32'h9A);
    cdb(3'd0, 32'h9A);
    idle();
    expect_st("late_cdb_retired", 4'd0, 1'b1, 3'd1);

    // Flush with a done head: no retirement, everything cleared
    do_reset("reset_before_flush");
    alloc(5'd4); alloc(5'd5); alloc(5'd6);
    cdb(3'd0, 32'h55);
    step(1'b1, 5'd7, 1'b0, 3'd0, 32'd0, 1'b1);
    expect_st("flush_cleared", 4'd0, 1'b1, 3'd0);
    cdb(3'd1, 32'h66);
    idle(); idle();
    expect_st("post_flush_cdb", 4'd0, 1'b1, 3'd0);

    // Asynchronous reset while a completed entry is about to retire
    alloc(5'd7);
    cdb(3'd0, 32'h77);
    do_reset("reset_midop");
    idle();
    expect_st("after_reset_midop", 4'd0, 1'b1, 3'd0);

    end_chk = 1'b1;
    @(negedge clk); #1;
    end_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
